// File: rtl/fetch_queue_if.sv
//------------------------------------------------------------------------------
// Module : fetch_queue_if
// Brief  : Memory, redirect and decode handshake bundle for fetch_queue.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_queue_if #(
  parameter int XLEN        = 32,
  parameter int FETCH_WIDTH = 32
);
  logic                   flush_valid;
  logic [XLEN-1:0]        flush_addr;
  logic                   mem_valid;
  logic [XLEN-1:0]        mem_addr;
  logic                   mem_ready;
  logic [FETCH_WIDTH-1:0] mem_rdata;
  logic                   out_valid;
  logic [XLEN-1:0]        out_pc;
  logic [31:0]            out_instr;
  logic                   out_ready;

  modport master (
    input  flush_valid, flush_addr, mem_ready, mem_rdata, out_ready,
    output mem_valid, mem_addr, out_valid, out_pc, out_instr
  );

  modport slave (
    output flush_valid, flush_addr, mem_ready, mem_rdata, out_ready,
    input  mem_valid, mem_addr, out_valid, out_pc, out_instr
  );
endinterface

`default_nettype wire

// File: rtl/fetch_queue.sv
//------------------------------------------------------------------------------
// Module : fetch_queue
// Brief  : Prefetch queue of halfwords emitting aligned 16/32-bit RISC-V instrs.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_queue #(
  parameter int              XLEN        = 32,
  parameter int              FETCH_WIDTH = 32,
  parameter int              DEPTH       = 8,
  parameter logic [XLEN-1:0] RESET_ADDR  = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);

  localparam int W  = FETCH_WIDTH / 16;
  localparam int BW = $clog2(FETCH_WIDTH / 8);
  localparam int SW = BW - 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]      state;
  logic [XLEN-1:0] faddr;
  logic [XLEN-1:0] req_addr;
  logic [SW-1:0]   skip;
  logic            drop;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [XLEN-1:0] pc;
  logic [15:0]     q [DEPTH];

  logic [PW-1:0]   rd_nxt;
  logic [15:0]     h0;
  logic [15:0]     h1;
  logic            is32;
  logic            fire;
  logic            rsp;
  logic            rsp_ok;
  logic            issue;
  logic [CW-1:0]   pop_n;
  logic [CW-1:0]   push_n;
  logic [CW-1:0]   free_n;

  always_comb begin
    rd_nxt = rd_ptr + PW'(1);
    h0     = q[rd_ptr];
    h1     = q[rd_nxt];
    is32   = (h0[1:0] == 2'b11);
    bus.out_valid = is32 ? (count >= CW'(2)) : (count != '0);
    bus.out_instr = !bus.out_valid ? 32'h0000_0013 :
                    is32           ? {h1, h0} : {16'h0000, h0};
    bus.out_pc    = pc;
    bus.mem_valid = (state == S_WAIT);
    bus.mem_addr  = req_addr;

    fire   = bus.out_valid & bus.out_ready & ~bus.flush_valid;
    pop_n  = fire ? (is32 ? CW'(2) : CW'(1)) : '0;
    rsp    = (state == S_WAIT) & bus.mem_ready;
    rsp_ok = rsp & ~drop & ~bus.flush_valid;
    push_n = rsp_ok ? (CW'(W) - CW'(skip)) : '0;
    free_n = CW'(DEPTH) - count;
    // Registered occupancy only: a pop in this cycle does not open room yet.
    issue  = (state == S_IDLE) & (free_n >= CW'(W)) & ~bus.flush_valid;
  end

  // Halfwords below the entry offset of a redirect are never written.
  always_ff @(posedge clk) begin
    if (rsp_ok) begin
      for (int i = 0; i < W; i++) begin
        if (i >= int'(skip)) begin
          q[wr_ptr + PW'(i) - PW'(skip)] <= bus.mem_rdata[16*i +: 16];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      faddr    <= {RESET_ADDR[XLEN-1:BW], {BW{1'b0}}};
      req_addr <= '0;
      skip     <= RESET_ADDR[BW-1:1];
      drop     <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      pc       <= RESET_ADDR;
    end else if (bus.flush_valid) begin
      count  <= '0;
      rd_ptr <= wr_ptr;
      pc     <= bus.flush_addr & ~XLEN'(1);
      faddr  <= {bus.flush_addr[XLEN-1:BW], {BW{1'b0}}};
      skip   <= bus.flush_addr[BW-1:1];
      if (state == S_WAIT) begin
        if (bus.mem_ready) begin
          state <= S_IDLE;
          drop  <= 1'b0;
        end else begin
          drop  <= 1'b1;
        end
      end
    end else begin
      count  <= count + push_n - pop_n;
      rd_ptr <= rd_ptr + PW'(pop_n);
      if (fire) begin
        pc <= pc + (is32 ? XLEN'(4) : XLEN'(2));
      end
      if (issue) begin
        state    <= S_WAIT;
        req_addr <= faddr;
      end else if (rsp) begin
        state <= S_IDLE;
        if (drop) begin
          drop <= 1'b0;
        end else begin
          wr_ptr <= wr_ptr + PW'(push_n);
          skip   <= '0;
          faddr  <= faddr + XLEN'(FETCH_WIDTH / 8);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
//------------------------------------------------------------------------------
// Module : tb_fetch_queue
// Brief  : Scoreboard bench for fetch_queue in 32-bit and 64-bit fetch configs.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        flush_valid = 1'b0;
  logic [31:0] flush_addr = '0;
  logic        out_ready = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] rd32 = '0;
  logic [63:0] rd64 = '0;

  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(32), .FETCH_WIDTH(32)) f32 ();
  fetch_queue_if #(.XLEN(32), .FETCH_WIDTH(64)) f64 ();

  fetch_queue #(.XLEN(32), .FETCH_WIDTH(32), .DEPTH(8), .RESET_ADDR(32'h100)) dut32 (
    .clk(clk), .rst(rst), .bus(f32));
  fetch_queue #(.XLEN(32), .FETCH_WIDTH(64), .DEPTH(16), .RESET_ADDR(32'h0)) dut64 (
    .clk(clk), .rst(rst), .bus(f64));

  assign f32.flush_valid = flush_valid & ~sel;
  assign f64.flush_valid = flush_valid & sel;
  assign f32.flush_addr  = flush_addr;
  assign f64.flush_addr  = flush_addr;
  assign f32.out_ready   = out_ready & ~sel;
  assign f64.out_ready   = out_ready & sel;
  assign f32.mem_ready   = mem_ready & ~sel;
  assign f64.mem_ready   = mem_ready & sel;
  assign f32.mem_rdata   = rd32;
  assign f64.mem_rdata   = rd64;

  logic        cur_mem_valid, cur_out_valid;
  logic [31:0] cur_mem_addr, cur_out_pc, cur_out_instr;
  assign cur_mem_valid = sel ? f64.mem_valid : f32.mem_valid;
  assign cur_mem_addr  = sel ? f64.mem_addr  : f32.mem_addr;
  assign cur_out_valid = sel ? f64.out_valid : f32.out_valid;
  assign cur_out_pc    = sel ? f64.out_pc    : f32.out_pc;
  assign cur_out_instr = sel ? f64.out_instr : f32.out_instr;

  int          n_chk = 0;
  int          n_pass = 0;
  int          mem_wait = 0;
  int          waitcnt = 0;
  bit          in_req = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] issue_log [$];
  logic [31:0] sb_pc [$];
  logic [31:0] sb_in [$];
  logic [31:0] img [logic [31:0]];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    return img.exists(k) ? img[k] : 32'h0000_0013;
  endfunction

  function automatic logic [15:0] hw(input logic [31:0] a);
    logic [31:0] w;
    w = word(a);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Reference decode of the memory image from a start PC.
  task automatic sb_load(input logic [31:0] a, input int n);
    logic [31:0] p;
    logic [15:0] h;
    p = a;
    for (int i = 0; i < n; i++) begin
      h = hw(p);
      sb_pc.push_back(p);
      if (h[1:0] == 2'b11) begin
        sb_in.push_back({hw(p + 32'd2), h});
        p = p + 32'd4;
      end else begin
        sb_in.push_back({16'h0000, h});
        p = p + 32'd2;
      end
    end
  endtask

  task automatic cycle();
    mem_ready = 1'b0;
    if (cur_mem_valid && !rst) begin
      if (!in_req) begin
        in_req   = 1'b1;
        req_addr = cur_mem_addr;
        waitcnt  = 0;
        issue_log.push_back(cur_mem_addr);
      end
      if (waitcnt >= mem_wait) mem_ready = 1'b1;
      else waitcnt++;
    end
    rd32 = word(f32.mem_addr);
    rd64 = {word(f64.mem_addr + 32'd4), word(f64.mem_addr)};
    if (mem_ready) begin
      check_eq("mem_addr_stable", cur_mem_addr, req_addr);
      in_req = 1'b0;
    end
    out_ready = (sb_pc.size() > 0) && !flush_valid;
    if (cur_out_valid && out_ready && !rst) begin
      check_eq("out_pc", cur_out_pc, sb_pc.pop_front());
      check_eq("out_instr", cur_out_instr, sb_in.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_empty(input int limit);
    int n;
    n = 0;
    while (sb_pc.size() > 0 && n < limit) begin
      cycle();
      n++;
    end
    check_eq("drain_timeout", sb_pc.size(), 0);
  endtask

  task automatic do_flush(input logic [31:0] a);
    sb_pc.delete();
    sb_in.delete();
    flush_valid = 1'b1;
    flush_addr  = a;
    cycle();
    flush_valid = 1'b0;
    check_eq("flush_outv", cur_out_valid, 0);
    issue_log.delete();
  endtask

  initial begin
    img[32'h0]    = 32'h0013_0001;
    img[32'h4]    = 32'h0000_4501;
    img[32'h204]  = 32'h4501_0013;
    img[32'h300]  = 32'h0001_0001;
    img[32'h400]  = 32'h4501_4501;
    img[32'h1004] = 32'h0013_0000;
    img[32'h1008] = 32'h0001_4501;

    // Reset state
    rst = 1'b1;
    cycle();
    cycle();
    check_eq("rst_mem_valid", cur_mem_valid, 0);
    check_eq("rst_out_valid", cur_out_valid, 0);
    check_eq("rst_out_pc", cur_out_pc, 32'h100);
    check_eq("rst_out_instr", cur_out_instr, 32'h13);
    rst = 1'b0;
    in_req = 1'b0;
    issue_log.delete();

    // Sequential fetch from RESET_ADDR
    sb_load(32'h100, 3);
    run_until_empty(50);
    check_eq("seq_addr0", issue_log[0], 32'h100);
    check_eq("seq_addr1", issue_log[1], 32'h104);
    check_eq("seq_addr2", issue_log[2], 32'h108);

    // Mixed widths with a straddling 32-bit instruction
    do_flush(32'h0);
    sb_load(32'h0, 3);
    run_until_empty(50);

    // Mid-word redirect skips the leading halfword
    do_flush(32'h206);
    sb_load(32'h206, 2);
    run_until_empty(50);
    check_eq("flush206_addr", issue_log[0], 32'h204);

    // Redirect while a slow request is outstanding
    mem_wait = 3;
    do_flush(32'h300);
    begin
      int n;
      n = 0;
      while (!(in_req && cur_mem_addr == 32'h300) && n < 20) begin
        cycle();
        n++;
      end
    end
    check_eq("wait_req_seen", in_req && cur_mem_addr == 32'h300, 1);
    do_flush(32'h400);
    sb_load(32'h400, 3);
    run_until_empty(80);
    check_eq("wait_flush_addr", issue_log[0], 32'h400);

    // Backpressure: queue fills and issue stops
    mem_wait = 0;
    do_flush(32'h500);
    repeat (30) cycle();
    check_eq("bp_issues", issue_log.size(), 4);
    check_eq("bp_addr3", issue_log[3], 32'h50c);
    check_eq("bp_mem_idle", cur_mem_valid, 0);
    sb_load(32'h500, 6);
    run_until_empty(80);
    check_eq("bp_resume_addr", issue_log[4], 32'h510);

    // 64-bit fetch, redirect to the last halfword of a fetch word
    sel = 1'b1;
    in_req = 1'b0;
    waitcnt = 0;
    do_flush(32'h1006);
    sb_load(32'h1006, 3);
    run_until_empty(60);
    check_eq("f64_addr0", issue_log[0], 32'h1000);
    check_eq("f64_addr1", issue_log[1], 32'h1008);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
